// File: rtl/fifo_deserializer.sv
// fifo_deserializer: drains 1-bit async-FIFO entries in the read domain
// and packs them into double-buffered WORD_W-bit words on a valid/ready port.
module fifo_deserializer #(
  parameter int WORD_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int RD_LAT    = 1
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic              fifo_data,
  output logic              fifo_rd_req,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  input  logic              flush,
  output logic [15:0]       words_done
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [CW:0]   WORD_N = (CW+1)'(WORD_W);
  localparam logic [CW-1:0] LAST   = CW'(WORD_W - 1);

  if (RD_LAT != 1 || WORD_W < 2 || WORD_W > 32) begin : g_bad_cfg
    $error("fifo_deserializer: unsupported parameters");
  end

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] sh_next;
  logic [CW-1:0]     bit_cnt;
  logic              inflight;
  logic [CW:0]       need;
  logic              accept;
  logic              slot_ok;

  // bits already captured plus the one still on its way from the FIFO
  assign need    = {1'b0, bit_cnt} + {{CW{1'b0}}, inflight};
  assign accept  = word_valid & word_ready;
  assign slot_ok = ~word_valid | word_ready;

  assign fifo_rd_req = rst & ~fifo_empty & ~flush &
                       (state != FULL) & (need < WORD_N);

  always_comb begin
    sh_next = shreg;
    if (MSB_FIRST != 0)
      sh_next = {shreg[WORD_W-2:0], fifo_data};
    else
      sh_next = {fifo_data, shreg[WORD_W-1:1]};
  end

  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      inflight   <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      words_done <= '0;
    end else begin
      inflight <= fifo_rd_req;
      if (accept) begin
        words_done <= words_done + 16'd1;
        word_valid <= 1'b0;
      end
      if (flush) begin
        shreg   <= '0;
        bit_cnt <= '0;
        state   <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (fifo_rd_req)
              state <= FILL;
          end
          FILL: begin
            if (inflight) begin
              if (bit_cnt == LAST && slot_ok) begin
                word_out   <= sh_next;
                word_valid <= 1'b1;
                shreg      <= '0;
                bit_cnt    <= '0;
                state      <= fifo_rd_req ? FILL : IDLE;
              end else begin
                shreg   <= sh_next;
                bit_cnt <= bit_cnt + CW'(1);
                if (bit_cnt == LAST)
                  state <= FULL;
              end
            end
          end
          FULL: begin
            if (accept) begin
              word_out   <= shreg;
              word_valid <= 1'b1;
              shreg      <= '0;
              bit_cnt    <= '0;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_deserializer.sv
// tb_fifo_deserializer: scoreboard bench, two DUTs (MSB-first and
// LSB-first) fed the same bit stream from a 1-cycle-latency FIFO model.
module tb_fifo_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic word_ready = 1'b0;

  logic       empty_m, empty_l;
  logic       data_m = 1'b0;
  logic       data_l = 1'b0;
  logic       req_m, req_l;
  logic [7:0] wo_m, wo_l;
  logic       wv_m, wv_l;
  logic [15:0] wd_m, wd_l;

  bit mem [512];
  int wp = 0;
  int rp_m = 0;
  int rp_l = 0;
  int underflow = 0;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_m[$];
  logic [7:0] exp_l[$];

  always #5 clk = ~clk;

  fifo_deserializer #(.WORD_W(8), .MSB_FIRST(1), .RD_LAT(1)) dut_m (
    .rd_clk(clk), .rst(rst), .fifo_empty(empty_m), .fifo_data(data_m),
    .fifo_rd_req(req_m), .word_out(wo_m), .word_valid(wv_m),
    .word_ready(word_ready), .flush(flush), .words_done(wd_m)
  );

  fifo_deserializer #(.WORD_W(8), .MSB_FIRST(0), .RD_LAT(1)) dut_l (
    .rd_clk(clk), .rst(rst), .fifo_empty(empty_l), .fifo_data(data_l),
    .fifo_rd_req(req_l), .word_out(wo_l), .word_valid(wv_l),
    .word_ready(word_ready), .flush(flush), .words_done(wd_l)
  );

  assign empty_m = (rp_m == wp);
  assign empty_l = (rp_l == wp);

  // FIFO read port model: data valid one cycle after the pop
  always @(posedge clk) begin
    if (req_m) begin
      if (rp_m == wp) underflow++;
      else begin
        data_m <= mem[rp_m];
        rp_m <= rp_m + 1;
      end
    end
    if (req_l) begin
      if (rp_l == wp) underflow++;
      else begin
        data_l <= mem[rp_l];
        rp_l <= rp_l + 1;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && word_ready) begin
      if (wv_m) begin
        tests++;
        if (exp_m.size() == 0) begin
          fails++;
          $display("FAIL msb_word: got %0h, none expected", wo_m);
        end else begin
          logic [7:0] e;
          e = exp_m.pop_front();
          if (wo_m !== e) begin
            fails++;
            $display("FAIL msb_word: got %0h expected %0h", wo_m, e);
          end
        end
      end
      if (wv_l) begin
        tests++;
        if (exp_l.size() == 0) begin
          fails++;
          $display("FAIL lsb_word: got %0h, none expected", wo_l);
        end else begin
          logic [7:0] e;
          e = exp_l.pop_front();
          if (wo_l !== e) begin
            fails++;
            $display("FAIL lsb_word: got %0h expected %0h", wo_l, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mem[wp] = v[i];
      wp = wp + 1;
    end
  endtask

  task automatic expect_word(input logic [7:0] m, input logic [7:0] l);
    exp_m.push_back(m);
    exp_l.push_back(l);
  endtask

  task automatic wait_drain(input string name, input int max);
    int k;
    k = 0;
    while ((exp_m.size() != 0 || exp_l.size() != 0) && k < max) begin
      step(1);
      k++;
    end
    if (exp_m.size() != 0 || exp_l.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, %0d/%0d words pending", name,
               exp_m.size(), exp_l.size());
      exp_m.delete();
      exp_l.delete();
    end
    step(2);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  initial begin
    int n;
    int p0;

    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wo_m", 32'(wo_m), 0);
    chk("rst_wv_m", 32'(wv_m), 0);
    chk("rst_wd_m", 32'(wd_m), 0);
    chk("rst_req_m", 32'(req_m), 0);
    chk("rst_wv_l", 32'(wv_l), 0);
    rst = 1'b1;
    step(3);
    chk("idle_req_m", 32'(req_m), 0);

    // basic word and latency
    word_ready = 1'b1;
    p0 = rp_m;
    expect_word(8'hA5, 8'hA5);
    push(32'hA5, 8);
    n = 0;
    while (!wv_m && n < 20) begin
      step(1);
      n++;
    end
    chk("first_latency", 32'(n), 9);
    step(1);
    chk("valid_pulse", 32'(wv_m), 0);
    chk("basic_pops", 32'(rp_m - p0), 8);
    chk("basic_done", 32'(wd_m), 1);

    // bit order
    expect_word(8'hC0, 8'h03);
    push(32'hC0, 8);
    wait_drain("order", 40);
    chk("order_done_l", 32'(wd_l), 2);

    // back-pressure
    do_reset();
    word_ready = 1'b0;
    p0 = rp_m;
    expect_word(8'h12, 8'h48);
    expect_word(8'h34, 8'h2C);
    expect_word(8'h56, 8'h6A);
    push(32'h123456, 24);
    step(12);
    chk("bp_wv", 32'(wv_m), 1);
    chk("bp_wo_m", 32'(wo_m), 32'h12);
    chk("bp_wo_l", 32'(wo_l), 32'h48);
    step(18);
    chk("bp_hold_m", 32'(wo_m), 32'h12);
    chk("bp_hold_wv", 32'(wv_m), 1);
    chk("bp_pops", 32'(rp_m - p0), 16);
    chk("bp_req", 32'(req_m), 0);
    word_ready = 1'b1;
    step(1);
    chk("bp_nobubble_wv", 32'(wv_m), 1);
    chk("bp_nobubble_wo", 32'(wo_m), 32'h34);
    wait_drain("backpressure", 40);
    chk("bp_done_m", 32'(wd_m), 3);
    chk("bp_done_l", 32'(wd_l), 3);
    chk("bp_pops_all", 32'(rp_l - p0), 24);

    // starvation, flush, pause-and-resume
    do_reset();
    word_ready = 1'b1;
    p0 = rp_m;
    push(32'b10110, 5);
    step(10);
    chk("starve_wv", 32'(wv_m), 0);
    chk("starve_pops", 32'(rp_m - p0), 5);
    flush = 1'b1;
    expect_word(8'hFF, 8'hFF);
    push(32'hFF, 8);
    #1;
    chk("flush_req", 32'(req_m), 0);
    step(1);
    chk("flush_nopop", 32'(rp_m - p0), 5);
    flush = 1'b0;
    wait_drain("flush", 40);
    expect_word(8'hB4, 8'h2D);
    push(32'b101, 3);
    step(8);
    chk("pause_wv", 32'(wv_m), 0);
    push(32'b10100, 5);
    wait_drain("pause", 40);
    chk("pause_done", 32'(wd_m), 2);

    // reset mid-word
    do_reset();
    word_ready = 1'b1;
    expect_word(8'h3C, 8'h3C);
    push(32'h3C, 8);
    wait_drain("pre_reset", 40);
    word_ready = 1'b0;
    push(32'h66, 8);
    step(12);
    chk("mid_wv", 32'(wv_m), 1);
    chk("mid_done", 32'(wd_m), 1);
    push(32'b1010, 4);
    step(8);
    #3;
    rst = 1'b0;
    #1;
    chk("async_wv_m", 32'(wv_m), 0);
    chk("async_wo_m", 32'(wo_m), 0);
    chk("async_wd_m", 32'(wd_m), 0);
    chk("async_wv_l", 32'(wv_l), 0);
    step(2);
    rst = 1'b1;
    step(1);
    word_ready = 1'b1;
    expect_word(8'h81, 8'h81);
    push(32'h81, 8);
    wait_drain("post_reset", 40);
    chk("post_done", 32'(wd_m), 1);

    chk("no_underflow", 32'(underflow), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
